// File: rtl/udpv4_rx_socket_buffer_pkg.sv
// udpv4_rx_socket_buffer_pkg: shared UDPv4 receive bus, header record and write FSM state types
package udpv4_rx_socket_buffer_pkg;
  typedef struct packed {
    logic        start;
    logic        headers_valid;
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [15:0] payload_len;
    logic        data_valid;
    logic [2:0]  bytes_valid;
    logic [31:0] data;
    logic        commit;
    logic        drop;
  } UDPv4RxBus;
  typedef struct packed {
    logic [31:0] src_ip;
    logic [15:0] src_port;
    logic [15:0] len;
  } udp_hdr_t;
  localparam int HDR_W = $bits(udp_hdr_t);
  typedef enum logic [1:0] {IDLE, ACCEPT, DISCARD} wr_state_t;
endpackage

// File: rtl/udpv4_rx_socket_buffer_fifo.sv
// udpv4_rx_socket_buffer_fifo: single-clock FIFO with combinational head output
//   push/din write, pop retires head, dout = head entry, full/empty flags
module udpv4_rx_socket_buffer_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  assign empty = r_wp == r_rp;
  assign full = (r_wp[AW-1:0] == r_rp[AW-1:0]) && (r_wp[AW] != r_rp[AW]);
  assign dout = r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (push && !full) r_wp <= r_wp + (AW+1)'(1);
      if (pop && !empty) r_rp <= r_rp + (AW+1)'(1);
    end
  end
  always_ff @(posedge clk) if (push && !full) r_mem[r_wp[AW-1:0]] <= din;
endmodule

// File: rtl/udpv4_rx_socket_buffer.sv
// udpv4_rx_socket_buffer: UDP socket receive buffer with commit/rollback payload RAM and header queue
//   udpv4_rx_bus        : frame stream from the UDP parser (start/headers/data/commit/drop)
//   frame_*             : head committed frame (valid, source IP/port, payload length)
//   rd_en/rd_*          : word reader, data one cycle after rd_en, bytes_valid and last marker
//   perf_accepted/dropped : free-running frame counters
module udpv4_rx_socket_buffer
  import udpv4_rx_socket_buffer_pkg::*;
#(
  parameter logic [15:0] LISTEN_PORT = 16'd0,
  parameter int          DATA_DEPTH  = 512,
  parameter int          HDR_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  UDPv4RxBus   udpv4_rx_bus,
  output logic        frame_valid,
  output logic [31:0] frame_src_ip,
  output logic [15:0] frame_src_port,
  output logic [15:0] frame_len,
  input  logic        rd_en,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [2:0]  rd_bytes_valid,
  output logic        rd_last,
  output logic [31:0] perf_accepted,
  output logic [31:0] perf_dropped
);
  localparam int AW = $clog2(DATA_DEPTH);
  wr_state_t r_state, w_state_nxt;
  logic [31:0] r_ram [DATA_DEPTH];
  logic [AW:0] r_tent, r_pub, r_rd, w_tent_nxt;
  logic [15:0] r_off, w_rem;
  logic [31:0] r_acc, r_drp, r_rd_data;
  logic [2:0] r_rd_bytes;
  logic r_ovf, r_rd_valid, r_rd_last;
  logic w_match, w_ram_full, w_wr, w_ovf_set, w_push, w_rollback, w_drop_cnt, w_latch;
  logic w_hdr_full, w_hdr_empty, w_issue, w_last, w_rd_word, w_unused;
  udp_hdr_t r_hdr, w_head;
  assign w_unused = ^udpv4_rx_bus.bytes_valid;
  assign w_match = udpv4_rx_bus.dst_port == LISTEN_PORT;
  // Full compares the tentative pointer so uncommitted words also consume space.
  assign w_ram_full = (r_tent[AW-1:0] == r_rd[AW-1:0]) && (r_tent[AW] != r_rd[AW]);
  always_comb begin
    w_state_nxt = r_state;
    w_wr = 1'b0;
    w_ovf_set = 1'b0;
    w_push = 1'b0;
    w_rollback = 1'b0;
    w_drop_cnt = 1'b0;
    w_latch = 1'b0;
    if (udpv4_rx_bus.start) begin
      w_state_nxt = IDLE;
      w_rollback = 1'b1;
    end else begin
      case (r_state)
        IDLE: if (udpv4_rx_bus.headers_valid) begin
          w_latch = w_match && !w_hdr_full;
          w_state_nxt = w_latch ? ACCEPT : DISCARD;
          w_drop_cnt = w_match && w_hdr_full;
        end
        ACCEPT: begin
          w_wr = udpv4_rx_bus.data_valid && !w_ram_full;
          w_ovf_set = udpv4_rx_bus.data_valid && w_ram_full;
          if (udpv4_rx_bus.commit) begin
            w_state_nxt = IDLE;
            w_push = !(r_ovf || w_ovf_set);
            w_rollback = !w_push;
            w_drop_cnt = !w_push;
          end else if (udpv4_rx_bus.drop) begin
            w_state_nxt = IDLE;
            w_rollback = 1'b1;
            w_drop_cnt = 1'b1;
          end
        end
        DISCARD: w_state_nxt = (udpv4_rx_bus.commit || udpv4_rx_bus.drop) ? IDLE : DISCARD;
        default: w_state_nxt = IDLE;
      endcase
    end
    w_tent_nxt = r_tent + {{AW{1'b0}}, w_wr};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_tent <= '0;
      r_pub <= '0;
      r_ovf <= 1'b0;
      r_hdr <= '0;
      r_acc <= '0;
      r_drp <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tent <= w_rollback ? r_pub : w_tent_nxt;
      r_pub <= w_push ? w_tent_nxt : r_pub;
      r_ovf <= w_latch ? 1'b0 : (r_ovf | w_ovf_set);
      r_hdr <= w_latch ? {udpv4_rx_bus.src_ip, udpv4_rx_bus.src_port, udpv4_rx_bus.payload_len} : r_hdr;
      r_acc <= r_acc + {31'd0, w_push};
      r_drp <= r_drp + {31'd0, w_drop_cnt};
    end
  end
  always_ff @(posedge clk) if (w_wr) r_ram[r_tent[AW-1:0]] <= udpv4_rx_bus.data;
  udpv4_rx_socket_buffer_fifo #(.WIDTH(HDR_W), .DEPTH(HDR_DEPTH)) u_hdr_fifo (
    .clk(clk), .rst_n(rst_n), .push(w_push), .din(r_hdr), .pop(w_issue && w_last),
    .dout(w_head), .full(w_hdr_full), .empty(w_hdr_empty)
  );
  assign frame_valid = !w_hdr_empty;
  assign frame_src_ip = w_head.src_ip;
  assign frame_src_port = w_head.src_port;
  assign frame_len = w_head.len;
  // A zero-length frame still takes one rd_en but consumes no RAM word.
  assign w_rem = w_head.len - r_off;
  assign w_issue = rd_en && frame_valid;
  assign w_last = w_rem <= 16'd4;
  assign w_rd_word = w_issue && (w_rem != 16'd0);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd <= '0;
      r_off <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last <= 1'b0;
      r_rd_bytes <= '0;
    end else begin
      r_rd <= r_rd + {{AW{1'b0}}, w_rd_word};
      r_off <= w_issue ? (w_last ? 16'd0 : r_off + 16'd4) : r_off;
      r_rd_valid <= w_issue;
      r_rd_last <= w_issue && w_last;
      r_rd_bytes <= w_issue ? (w_last ? w_rem[2:0] : 3'd4) : 3'd0;
    end
  end
  always_ff @(posedge clk) r_rd_data <= r_ram[r_rd[AW-1:0]];
  assign rd_valid = r_rd_valid;
  assign rd_data = r_rd_data;
  assign rd_bytes_valid = r_rd_bytes;
  assign rd_last = r_rd_last;
  assign perf_accepted = r_acc;
  assign perf_dropped = r_drp;
endmodule

// File: tb/tb_udpv4_rx_socket_buffer.sv
// tb_udpv4_rx_socket_buffer: scoreboard bench with a queue-based reference model of the socket buffer
module tb_udpv4_rx_socket_buffer;
  import udpv4_rx_socket_buffer_pkg::*;
  localparam logic [15:0] LP = 16'd5000;
  localparam int DD = 8;
  localparam int HD = 16;
  typedef struct {logic [31:0] data; logic [2:0] bytes; logic last;} word_t;
  typedef struct {logic [31:0] ip; logic [15:0] port; logic [15:0] len;} hdr_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  UDPv4RxBus bus;
  logic rd_en;
  logic frame_valid, rd_valid, rd_last;
  logic [31:0] frame_src_ip, rd_data, perf_accepted, perf_dropped;
  logic [15:0] frame_src_port, frame_len;
  logic [2:0] rd_bytes_valid;
  word_t exp_w[$];
  hdr_t exp_h[$];
  word_t mon_e;
  hdr_t mon_h;
  int checks = 0;
  int failures = 0;
  int pend_frames = 0;
  int pend_words = 0;
  logic [31:0] m_acc = 0;
  logic [31:0] m_drp = 0;
  bit rd_on = 1'b0;
  bit new_frame = 1'b1;

  always #5 clk = ~clk;

  udpv4_rx_socket_buffer #(.LISTEN_PORT(LP), .DATA_DEPTH(DD), .HDR_DEPTH(HD)) dut (
    .clk(clk), .rst_n(rst_n), .udpv4_rx_bus(bus),
    .frame_valid(frame_valid), .frame_src_ip(frame_src_ip), .frame_src_port(frame_src_port),
    .frame_len(frame_len), .rd_en(rd_en), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_bytes_valid(rd_bytes_valid), .rd_last(rd_last),
    .perf_accepted(perf_accepted), .perf_dropped(perf_dropped)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s", nm);
  endtask

  // Monitor: words are checked whenever rd_valid shows; the head header is
  // checked when the first read of a frame is issued.
  always @(negedge clk) begin
    if (!rst_n) new_frame = 1'b1;
    else begin
      if (rd_valid) begin
        if (exp_w.size() == 0) fail_now("rd_spurious: rd_valid=1 with nothing expected");
        else begin
          mon_e = exp_w.pop_front();
          chk("rd_bytes_valid", 32'(rd_bytes_valid), 32'(mon_e.bytes));
          chk("rd_last", 32'(rd_last), 32'(mon_e.last));
          if (mon_e.bytes != 3'd0) begin
            chk("rd_data", rd_data, mon_e.data);
            pend_words--;
          end
          if (mon_e.last) begin
            pend_frames--;
            new_frame = 1'b1;
          end
        end
      end
      if (rd_en && frame_valid && new_frame) begin
        new_frame = 1'b0;
        if (exp_h.size() == 0) fail_now("frame_spurious: frame_valid=1 with no frame expected");
        else begin
          mon_h = exp_h.pop_front();
          chk("frame_len", 32'(frame_len), 32'(mon_h.len));
          chk("frame_src_ip", frame_src_ip, mon_h.ip);
          chk("frame_src_port", 32'(frame_src_port), 32'(mon_h.port));
        end
      end
    end
  end

  initial begin
    rd_en = 1'b0;
    forever begin
      @(posedge clk);
      #1 rd_en = rd_on && ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [15:0] port, input int len, input bit do_commit, input bit gaps);
    int nw = (len + 3) / 4;
    logic [31:0] d[$];
    hdr_t h;
    h.ip = $urandom;
    h.port = 16'($urandom);
    h.len = 16'(len);
    for (int i = 0; i < nw; i++) d.push_back($urandom);
    if (port == LP) begin
      if (pend_frames >= HD || !do_commit || pend_words + nw > DD) m_drp++;
      else begin
        m_acc++;
        pend_frames++;
        pend_words += nw;
        exp_h.push_back(h);
        if (nw == 0) exp_w.push_back('{32'd0, 3'd0, 1'b1});
        for (int i = 0; i < nw; i++) begin
          int r = len - 4 * i;
          exp_w.push_back('{d[i], 3'(r > 4 ? 4 : r), i == nw - 1});
        end
      end
    end
    @(posedge clk); #1 bus = '0; bus.start = 1'b1;
    @(posedge clk); #1 bus = '0; bus.headers_valid = 1'b1; bus.src_ip = h.ip;
    bus.src_port = h.port; bus.dst_port = port; bus.payload_len = h.len;
    for (int i = 0; i < nw; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1 bus = '0;
      end
      @(posedge clk); #1 bus = '0; bus.data_valid = 1'b1; bus.data = d[i];
      bus.bytes_valid = 3'(len - 4 * i > 4 ? 4 : len - 4 * i);
    end
    @(posedge clk); #1 bus = '0;
    if (do_commit) bus.commit = 1'b1; else bus.drop = 1'b1;
    @(posedge clk); #1 bus = '0;
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int n = 0;
    rd_on = 1'b1;
    while ((exp_w.size() != 0 || frame_valid) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    rd_on = 1'b0;
    if (n >= 3000) fail_now("drain_timeout");
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("drained_frame_valid", 32'(frame_valid), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_frame_valid", 32'(frame_valid), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_rd_last", 32'(rd_last), 32'd0);
    chk("reset_perf_accepted", perf_accepted, 32'd0);
    chk("reset_perf_dropped", perf_dropped, 32'd0);
    rst_n = 1'b1;
    send(LP, 10, 1'b1, 1'b0);
    settle();
    chk("basic_frame_valid", 32'(frame_valid), 32'd1);
    chk("basic_frame_len", 32'(frame_len), 32'd10);
    chk("basic_perf_accepted", perf_accepted, m_acc);
    drain();
    send(LP + 16'd1, 12, 1'b1, 1'b0);
    settle();
    chk("mismatch_frame_valid", 32'(frame_valid), 32'd0);
    chk("mismatch_perf_dropped", perf_dropped, m_drp);
    send(LP, 6, 1'b0, 1'b0);
    settle();
    chk("drop_frame_valid", 32'(frame_valid), 32'd0);
    chk("drop_perf_dropped", perf_dropped, m_drp);
    send(LP, 8, 1'b1, 1'b0);
    drain();
    send(LP, 40, 1'b1, 1'b0);
    settle();
    chk("overflow_frame_valid", 32'(frame_valid), 32'd0);
    chk("overflow_perf_dropped", perf_dropped, m_drp);
    send(LP, 8, 1'b1, 1'b0);
    drain();
    for (int i = 0; i < 17; i++) send(LP, (i % 3 == 0) ? (i % 4 + 1) : 0, 1'b1, 1'b0);
    settle();
    chk("hdrfull_frame_valid", 32'(frame_valid), 32'd1);
    chk("hdrfull_perf_accepted", perf_accepted, m_acc);
    chk("hdrfull_perf_dropped", perf_dropped, m_drp);
    drain();
    rd_on = 1'b1;
    for (int k = 0; k < 60; k++) begin
      int n = 0;
      while ((pend_words > 3 || pend_frames > 8) && n < 2000) begin
        @(posedge clk);
        n++;
      end
      if (n >= 2000) fail_now("random_wait_timeout");
      send(($urandom_range(0, 3) == 0) ? 16'(LP + 16'd1 + 16'($urandom_range(0, 9))) : LP,
           $urandom_range(0, 12), $urandom_range(0, 4) != 0, 1'b1);
    end
    drain();
    chk("random_perf_accepted", perf_accepted, m_acc);
    chk("random_perf_dropped", perf_dropped, m_drp);
    send(LP, 8, 1'b1, 1'b0);
    @(posedge clk); #1 bus = '0; bus.start = 1'b1;
    @(posedge clk); #1 bus = '0; bus.headers_valid = 1'b1; bus.dst_port = LP; bus.payload_len = 16'd8;
    @(posedge clk); #1 bus = '0; bus.data_valid = 1'b1; bus.data = $urandom; bus.bytes_valid = 3'd4;
    #3 rst_n = 1'b0;
    bus = '0;
    exp_w.delete();
    exp_h.delete();
    pend_frames = 0;
    pend_words = 0;
    m_acc = 0;
    m_drp = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    settle();
    chk("midreset_frame_valid", 32'(frame_valid), 32'd0);
    chk("midreset_rd_valid", 32'(rd_valid), 32'd0);
    chk("midreset_perf_accepted", perf_accepted, m_acc);
    chk("midreset_perf_dropped", perf_dropped, m_drp);
    send(LP, 5, 1'b1, 1'b0);
    settle();
    chk("postreset_frame_valid", 32'(frame_valid), 32'd1);
    drain();
    chk("final_words_left", 32'(exp_w.size()), 32'd0);
    chk("final_headers_left", 32'(exp_h.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
